// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the execute-stage divider.
//   - data widths (RegBus / DoubleRegBus)
//   - divider FSM state encoding (2-bit)
//   - handshake level constants
//   - neg_if(): conditional two's-complement negate used for sign handling
package div_unit_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  function automatic logic [RegBus-1:0] neg_if(input logic [RegBus-1:0] v,
                                               input logic              neg);
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute stage and the divider.
//   master (execute stage): drives signed_div_i, opdata1_i, opdata2_i, start_i, annul_i;
//                           observes result_o {remainder, quotient} and ready_o.
//   slave  (divider)      : the mirror image.
interface div_unit_if;
  import div_unit_pkg::*;

  logic                    signed_div_i;
  logic [RegBus-1:0]       opdata1_i;
  logic [RegBus-1:0]       opdata2_i;
  logic                    start_i;
  logic                    annul_i;
  logic [DoubleRegBus-1:0] result_o;
  logic                    ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit DIV/DIVU, restoring division, one quotient bit per clock.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous, active-high reset
//   bus - div_unit_if.slave: operands, start/annul in; result_o {rem, quot}, ready_o out
//
// state     | meaning
// ----------+-----------------------------------------------------------
// DivFree   | idle, outputs cleared, waiting for start_i
// DivByZero | divisor was zero; one dead cycle then DivEnd with zero result
// DivOn     | 32 shift/subtract iterations, then sign fix-up and result load
// DivEnd    | result presented while start_i is held; start_i low -> DivFree
module div_unit
  import div_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  div_state_e              state_q, state_d;
  logic [5:0]              cnt_q, cnt_d;
  logic [DoubleRegBus:0]   work_q, work_d;
  logic [RegBus-1:0]       divisor_q, divisor_d;
  logic                    neg1_q, neg1_d;
  logic                    neg2_q, neg2_d;
  logic [DoubleRegBus-1:0] result_q, result_d;
  logic                    ready_q, ready_d;

  logic [RegBus:0]         trial;
  logic [RegBus-1:0]       quot_fix;
  logic [RegBus-1:0]       rem_fix;

  // Partial remainder minus divisor; bit 32 set means the subtraction borrowed.
  assign trial = {1'b0, work_q[63:32]} - {1'b0, divisor_q};

  // neg1/neg2 are only ever set for signed divides, so no extra signed qualifier here.
  assign quot_fix = neg_if(work_q[31:0], neg1_q ^ neg2_q);
  assign rem_fix  = neg_if(work_q[64:33], neg1_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg1_d    = neg1_q;
    neg2_d    = neg2_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (bus.start_i == DivStart && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = '0;
            neg1_d    = bus.signed_div_i & bus.opdata1_i[31];
            neg2_d    = bus.signed_div_i & bus.opdata2_i[31];
            work_d    = {32'b0, neg_if(bus.opdata1_i, bus.signed_div_i & bus.opdata1_i[31]), 1'b0};
            divisor_d = neg_if(bus.opdata2_i, bus.signed_div_i & bus.opdata2_i[31]);
          end
        end
      end

      DivByZero: begin
        state_d = DivEnd;
        work_d  = '0;
      end

      DivOn: begin
        if (bus.annul_i) begin
          state_d = DivFree;
          cnt_d   = '0;
          ready_d = DivResultNotReady;
        end else if (cnt_q != 6'd32) begin
          if (trial[32]) begin
            work_d = {work_q[63:0], 1'b0};
          end else begin
            work_d = {trial[31:0], work_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = DivResultReady;
          state_d  = DivEnd;
          cnt_d    = '0;
        end
      end

      DivEnd: begin
        if (bus.start_i == DivStart) begin
          // Result register already holds the answer (zero on the divide-by-zero
          // path); raising ready here is what completes that path.
          ready_d = DivResultReady;
        end else begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end

      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg1_q    <= 1'b0;
      neg2_q    <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg1_q    <= neg1_d;
      neg2_q    <= neg2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit. The driver pushes the reference
// answer and expected latency when it raises start_i; an independent monitor
// pops and compares on every rising edge of ready_o.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  div_unit_if bus_if();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  logic mon_prev = 1'b0;

  // Reference: plain integer arithmetic with C-style truncation.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {r, q};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input string nm);
    exp_t e;
    bus_if.signed_div_i = s;
    bus_if.opdata1_i    = a;
    bus_if.opdata2_i    = b;
    bus_if.start_i      = 1'b1;
    e.res  = ref_div(s, a, b);
    e.lat  = (b == 32'd0) ? 2 : 33;
    e.t0   = cyc + 1;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // Hold start until ready, optionally scramble operands mid-flight, keep start
  // high for a few extra cycles, then drop it and check outputs clear one edge later.
  task automatic finish_txn(input string nm, input logic [63:0] exp_res, input bit scramble, input int hold);
    int n = 0;
    while (bus_if.ready_o !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
      if (scramble && n == 5) begin
        bus_if.opdata1_i = $urandom;
        bus_if.opdata2_i = $urandom;
      end
    end
    if (bus_if.ready_o !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s timeout: ready_o=%b want 1", nm, bus_if.ready_o);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({nm, " hold_ready"}, {63'd0, bus_if.ready_o}, 64'd1);
      check({nm, " hold_result"}, bus_if.result_o, exp_res);
    end
    bus_if.start_i = 1'b0;
    @(negedge clk);
    check({nm, " ready_fall"}, {63'd0, bus_if.ready_o}, 64'd0);
    check({nm, " result_clr"}, bus_if.result_o, 64'd0);
  endtask

  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b, input string nm, input bit scramble, input int hold);
    issue(s, a, b, nm);
    finish_txn(nm, ref_div(s, a, b), scramble, hold);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus_if.ready_o === 1'b1 && !mon_prev) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: result_o=%h, no request outstanding", bus_if.result_o);
        end else begin
          e = sb_q.pop_front();
          check({e.name, " result"}, bus_if.result_o, e.res);
          check({e.name, " latency"}, 64'(cyc - e.t0), 64'(e.lat));
        end
      end
      mon_prev = (bus_if.ready_o === 1'b1);
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    bit          seen;

    bus_if.signed_div_i = 1'b0;
    bus_if.opdata1_i    = '0;
    bus_if.opdata2_i    = '0;
    bus_if.start_i      = 1'b0;
    bus_if.annul_i      = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ready_o", {63'd0, bus_if.ready_o}, 64'd0);
    check("reset result_o", bus_if.result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run(1'b0, 32'd100,         32'd7,          "u100_7",      1'b0, 1);
    run(1'b1, 32'hFFFF_FFF9,   32'd2,          "s-7_2",       1'b1, 0);
    run(1'b1, 32'd7,           32'hFFFF_FFFE,  "s7_-2",       1'b1, 2);
    run(1'b0, 32'hFFFF_FFFF,   32'd1,          "uFFFF_1",     1'b0, 0);
    run(1'b1, 32'h8000_0000,   32'hFFFF_FFFF,  "s_overflow",  1'b1, 1);
    run(1'b0, 32'h0000_1234,   32'd0,          "u_div0",      1'b0, 1);
    run(1'b1, 32'h8765_4321,   32'd0,          "s_div0",      1'b0, 0);

    // Annul during the iteration phase: no result may ever appear.
    bus_if.signed_div_i = 1'b0;
    bus_if.opdata1_i    = 32'd50;
    bus_if.opdata2_i    = 32'd5;
    bus_if.start_i      = 1'b1;
    repeat (11) @(negedge clk);
    bus_if.annul_i = 1'b1;
    bus_if.start_i = 1'b0;
    @(negedge clk);
    bus_if.annul_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.ready_o !== 1'b0) seen = 1'b1;
    end
    check("annul no_ready", {63'd0, seen}, 64'd0);
    run(1'b0, 32'd9, 32'd3, "after_annul", 1'b0, 0);

    // Reset mid-division with start held; the request is re-run from scratch.
    bus_if.signed_div_i = 1'b1;
    bus_if.opdata1_i    = 32'hFFFF_FC18;
    bus_if.opdata2_i    = 32'd9;
    bus_if.start_i      = 1'b1;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst ready_o", {63'd0, bus_if.ready_o}, 64'd0);
    check("rst result_o", bus_if.result_o, 64'd0);
    rst = 1'b0;
    issue(1'b1, 32'hFFFF_FC18, 32'd9, "rst_restart");
    finish_txn("rst_restart", ref_div(1'b1, 32'hFFFF_FC18, 32'd9), 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin
          a = 32'h8000_0000;
          b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'd1;
        end
        3: b = b >> $urandom_range(8, 28);
        default: ;
      endcase
      run(s, a, b, $sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
